uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter DBIT, default 8, data bits per frame (5..8).
REQ-002 SHALL provide parameter SB_TICK, default 16, oversampling ticks in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 SHALL provide port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous active-low reset.
REQ-005 SHALL provide port s_tick  input  1  16x baud enable, one clk wide.
REQ-006 SHALL provide port fifo_empty  input  1  TX FIFO empty flag.
REQ-007 SHALL provide port fifo_data  input  DBIT  TX FIFO head word, valid while fifo_empty=0.
REQ-008 SHALL provide port fifo_rd  output  1  FIFO pop strobe, one clk wide.
REQ-009 SHALL provide port tx  output  1  serial line, registered, idle high.
REQ-010 SHALL provide port tx_busy  output  1  high in any state other than IDLE.
REQ-011 SHALL provide port tx_done_tick  output  1  one-clk pulse at the end of the stop bit.

Function
REQ-012 SHALL implement states IDLE, START, DATA, [PARITY], STOP using a tick counter s (4 bits), a bit counter n (3 bits) and a shift register b (DBIT bits).
REQ-013 SHALL, in IDLE with fifo_empty=0, load fifo_data into b, assert fifo_rd for that single cycle, clear s, and enter START on the next edge.
REQ-014 SHALL, in IDLE with fifo_empty=1, keep tx=1 and fifo_rd=0 indefinitely.
REQ-015 SHALL drive tx=0 starting on the first clk after entry to START; s SHALL increment only on s_tick=1; at s=15 with s_tick=1, clear s and n and enter DATA.
REQ-016 SHALL drive tx=b[0] in DATA; at s=15 with s_tick=1, shift b right by one and increment n; after the DATA with n=DBIT-1 completes, enter PARITY (macro on) or STOP.
REQ-017 SHALL drive tx=1 in STOP for SB_TICK ticks; at s=SB_TICK-1 with s_tick=1, pulse tx_done_tick and return to IDLE.
REQ-018 SHALL keep at least one clk in IDLE between frames, so the earliest next fifo_rd follows tx_done_tick by exactly 1 clk.
REQ-019 SHALL never assert fifo_rd outside IDLE, when fifo_empty=1, or while reset=0.
REQ-020 SHALL ignore fifo_empty and fifo_data changes while not in IDLE.
REQ-021 SHALL size s so that it covers SB_TICK-1 (for example, 5 bits when SB_TICK=32); counters SHALL not wrap within a state.
REQ-022 SHALL transmit data LSB first; each START, DATA and PARITY bit SHALL last exactly 16 s_tick pulses.

Reset
REQ-023 SHALL, on any rising clk with reset=0, set state=IDLE, s=0, n=0, b=0, tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0.
REQ-024 SHALL abort an in-progress frame on reset (the line returns high on the next edge and no tx_done_tick is produced), and SHALL not re-pop the aborted byte.

Configuration
REQ-025 SHALL, when macro UART_TX_PARITY_EN is defined, insert a PARITY state after DATA that drives tx = XOR of the DBIT data bits (even parity) for 16 ticks, then enters STOP.
REQ-026 SHALL, without UART_TX_PARITY_EN, contain no PARITY state or parity logic; the frame SHALL be start, DBIT data bits, stop.

Verification
REQ-027 SHALL verify single byte: DBIT=8, s_tick every 16 clk, FIFO holds 0xA5 -> one fifo_rd pulse; tx = 0,1,0,1,0,0,1,0,1,1, each bit 256 clk; one tx_done_tick; tx_busy high throughout the frame.
REQ-028 SHALL verify back-to-back: FIFO holds 0x00 then 0xFF -> two frames; the second fifo_rd comes exactly 1 clk after the first tx_done_tick; exactly 2 pops in total.
REQ-029 SHALL verify empty FIFO: fifo_empty=1 for 10000 clk -> tx=1, fifo_rd=0, tx_busy=0 throughout.
REQ-030 SHALL verify reset mid-frame: reset=0 for 1 clk during data bit 3 of 0x3C -> tx=1 on the next edge, state IDLE, no tx_done_tick; with the FIFO then empty, no further fifo_rd.
REQ-031 SHALL verify parity with UART_TX_PARITY_EN defined: 0xA5 -> parity bit 0; 0x07 -> parity bit 1; each frame 11 bits long.
REQ-032 SHALL verify s_tick held at 1 continuously: 0x81 -> each bit lasts 16 clk, and the stop bit lasts SB_TICK clk.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter that pops words from an external TX FIFO, 16x oversampled via s_tick.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  // s must reach SB_TICK-1 in the stop bit as well as 15 in the other bits
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam logic [SW-1:0] BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST    = 3'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_reg, state_next;
  logic [SW-1:0]   s_reg, s_next;
  logic [2:0]      n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            tx_reg, tx_next;
  logic            pop;
`ifdef UART_TX_PARITY_EN
  logic            p_reg, p_next;
`endif

  assign pop = reset && (state_reg == IDLE) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      p_reg     <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
`ifdef UART_TX_PARITY_EN
      p_reg     <= p_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
`ifdef UART_TX_PARITY_EN
    p_next     = p_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        if (pop) begin
          b_next     = fifo_data;
          s_next     = '0;
          state_next = START;
`ifdef UART_TX_PARITY_EN
          p_next     = ^fifo_data;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            s_next = '0;
            b_next = b_reg >> 1;
            // n is held at its last value on exit so it never wraps inside DATA
            if (n_reg == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n_reg + 3'd1;
            end
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_reg == STOP_LAST) begin
            s_next     = '0;
            state_next = IDLE;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx is registered, so each line level appears one clk after its state is entered
  always_comb begin
    tx_next      = 1'b1;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;
    unique case (state_reg)
      IDLE:   fifo_rd = pop;
      START:  tx_next = 1'b0;
      DATA:   tx_next = b_reg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_next = p_reg;
`endif
      STOP:   tx_done_tick = reset && s_tick && (s_reg == STOP_LAST);
      default: tx_next = 1'b1;
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = (state_reg != IDLE);

endmodule
